// File: rtl/meas_gate_ctrl_if.sv
// Control/status bundle between the measurement sequencer and the gate controller.
// The master drives the measured signals and requests; the slave returns counter controls.
interface meas_gate_ctrl_if;
    logic ina_in;
    logic inb_in;
    logic start;
    logic cont_mode;
    logic cnt_en;
    logic or_en;
    logic cnt_clr;
    logic up_data;
    logic q_up;
    logic busy;
    logic done;
    logic timeout_flag;

    modport master (
        output ina_in, inb_in, start, cont_mode,
        input  cnt_en, or_en, cnt_clr, up_data, q_up, busy, done, timeout_flag
    );

    modport slave (
        input  ina_in, inb_in, start, cont_mode,
        output cnt_en, or_en, cnt_clr, up_data, q_up, busy, done, timeout_flag
    );
endinterface

// File: rtl/meas_gate_ctrl.sv
// Gate-timing controller for the equal-precision counter: opens and closes the counting
// gate on synchronised rising edges of A, with timeout and single/continuous operation.
module meas_gate_ctrl #(
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    meas_gate_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_ARM,
        ST_GATE,
        ST_WAIT,
        ST_SETTLE,
        ST_UPD,
        ST_TOUT,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_meta_q;
    logic [1:0]       sync_q;
    logic             ina_d_q;
    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]       sub_cnt_q, sub_cnt_d;
    logic             timeout_flag_q, timeout_flag_d;
    logic             cnt_en_q, cnt_en_d;
    logic             or_en_q, or_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             up_data_q, up_data_d;
    logic             q_up_q, q_up_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ina_s;
    logic inb_s;
    logic rise_a;

    assign ina_s  = sync_q[0];
    assign inb_s  = sync_q[1];
    assign rise_a = ina_s & ~ina_d_q;

    always_comb begin
        state_d        = state_q;
        gate_cnt_d     = gate_cnt_q;
        to_cnt_d       = to_cnt_q;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_CLR;
            end
            ST_CLR: begin
                gate_cnt_d = '0;
                to_cnt_d   = '0;
                state_d    = ST_ARM;
            end
            ST_ARM: begin
                to_cnt_d = to_cnt_q + CNT_ONE;
                if (rise_a)                    state_d = ST_GATE;
                else if (to_cnt_q == TO_LAST)  state_d = ST_TOUT;
            end
            ST_GATE: begin
                gate_cnt_d = gate_cnt_q + CNT_ONE;
                // An A edge landing on the last minimum-gate cycle closes the gate right away,
                // so a period that divides GATE_CYCLES gives exactly GATE_CYCLES.
                if (gate_cnt_q == GATE_LAST) begin
                    to_cnt_d = '0;
                    state_d  = rise_a ? ST_SETTLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + CNT_ONE;
                if (rise_a)                    state_d = ST_SETTLE;
                else if (to_cnt_q == TO_LAST)  state_d = ST_TOUT;
            end
            ST_SETTLE: begin
                if (sub_cnt_q == 2'd1) state_d = ST_UPD;
            end
            ST_UPD:  state_d = ST_HOLD;
            ST_TOUT: state_d = ST_HOLD;
            ST_HOLD: begin
                if (sub_cnt_q == 2'd2) state_d = bus.cont_mode ? ST_CLR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dwell counter for SETTLE/HOLD restarts on every state change.
        sub_cnt_d = (state_d == state_q) ? sub_cnt_q + 2'd1 : 2'd0;

        if (state_d == ST_CLR)       timeout_flag_d = 1'b0;
        else if (state_d == ST_TOUT) timeout_flag_d = 1'b1;

        cnt_en_d  = (state_d == ST_GATE) || (state_d == ST_WAIT);
        or_en_d   = cnt_en_d & (ina_s ^ inb_s);
        cnt_clr_d = (state_d == ST_CLR);
        up_data_d = (state_d == ST_UPD);
        q_up_d    = (state_d == ST_TOUT);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_HOLD) && (sub_cnt_d == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sync_meta_q    <= 2'b00;
            sync_q         <= 2'b00;
            ina_d_q        <= 1'b0;
            gate_cnt_q     <= '0;
            to_cnt_q       <= '0;
            sub_cnt_q      <= 2'd0;
            timeout_flag_q <= 1'b0;
            cnt_en_q       <= 1'b0;
            or_en_q        <= 1'b0;
            cnt_clr_q      <= 1'b0;
            up_data_q      <= 1'b0;
            q_up_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_meta_q    <= {bus.inb_in, bus.ina_in};
            sync_q         <= sync_meta_q;
            ina_d_q        <= ina_s;
            gate_cnt_q     <= gate_cnt_d;
            to_cnt_q       <= to_cnt_d;
            sub_cnt_q      <= sub_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            cnt_en_q       <= cnt_en_d;
            or_en_q        <= or_en_d;
            cnt_clr_q      <= cnt_clr_d;
            up_data_q      <= up_data_d;
            q_up_q         <= q_up_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.cnt_en       = cnt_en_q;
    assign bus.or_en        = or_en_q;
    assign bus.cnt_clr      = cnt_clr_q;
    assign bus.up_data      = up_data_q;
    assign bus.q_up         = q_up_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.timeout_flag = timeout_flag_q;
endmodule

// File: tb/tb_meas_gate_ctrl.sv
// Bench for meas_gate_ctrl: periodic A/B waveforms with random period, duty and skew,
// checked against gate/event timing predicted from the waveform itself.
module tb_meas_gate_ctrl;
    localparam int G    = 100;
    localparam int T    = 400;
    localparam int MAXC = 40000;
    localparam int BIG  = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    meas_gate_ctrl_if bus ();

    meas_gate_ctrl #(
        .GATE_CYCLES   (G),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Waveform generator state; a_rec/b_rec hold the value sampled at each posedge.
    bit a_rec [MAXC];
    bit b_rec [MAXC];
    bit wave_en = 1'b0;
    int wave_t0 = 0, wave_p = 20, wave_h = 10, wave_d = -1, wave_stop = BIG;
    bit start_req = 1'b0;
    int last_c = 0;

    // Observed events, logged by cycle number.
    int clr_log[$], upd_log[$], qup_log[$], done_log[$], en_rise_log[$], en_fall_log[$];
    int or_count = 0, or_viol = 0, clr_viol = 0, both_viol = 0;
    int last_busy = -1, last_evt = -100;
    bit en_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.cnt_clr) begin
            if (cyc - last_evt < 4) clr_viol++;
            clr_log.push_back(cyc);
        end
        if (bus.up_data) begin upd_log.push_back(cyc); last_evt = cyc; end
        if (bus.q_up)    begin qup_log.push_back(cyc); last_evt = cyc; end
        if (bus.up_data && bus.q_up) both_viol++;
        if (bus.done) done_log.push_back(cyc);
        if (bus.cnt_en && !en_prev) en_rise_log.push_back(cyc);
        if (!bus.cnt_en && en_prev) en_fall_log.push_back(cyc);
        en_prev = bus.cnt_en;
        if (bus.or_en) or_count++;
        if (bus.or_en && !bus.cnt_en) or_viol++;
        if (bus.busy) last_busy = cyc;
    end

    function automatic bit wave_at(input int c, input int dly);
        if (!wave_en || dly < 0 || c >= wave_stop || c < wave_t0 + dly) return 1'b0;
        return ((c - wave_t0 - dly) % wave_p) < wave_h;
    endfunction

    function automatic int at_or_neg(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        int c;
        bit a, b;
        @(negedge clk);
        c = cyc + 1;
        a = wave_at(c, 0);
        b = wave_at(c, wave_d);
        bus.ina_in = a;
        bus.inb_in = b;
        if (c < MAXC) begin a_rec[c] = a; b_rec[c] = b; end
        bus.start = start_req;
        start_req = 1'b0;
        last_c = c;
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic wait_done(input int want, input int budget, output bit ok);
        int i = 0;
        while (done_log.size() < want && i < budget) begin step(); i++; end
        ok = (done_log.size() >= want);
    endtask

    task automatic clear_logs();
        clr_log.delete(); upd_log.delete(); qup_log.delete(); done_log.delete();
        en_rise_log.delete(); en_fall_log.delete();
        or_count = 0; or_viol = 0; clr_viol = 0; both_viol = 0; last_busy = -1;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        bus.ina_in = 0; bus.inb_in = 0; bus.start = 0; bus.cont_mode = 0;
        #1 rst_n = 1'b0;
        #1;
        outs = {bus.cnt_en, bus.or_en, bus.cnt_clr, bus.up_data, bus.q_up, bus.busy, bus.done, bus.timeout_flag};
        n_cmp++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_outs: got %b required 00000000", outs); end
        steps(3);
        #2 rst_n = 1'b1;
        clear_logs();
        steps(5);
        outs = {bus.cnt_en, bus.or_en, bus.cnt_clr, bus.up_data, bus.q_up, bus.busy, bus.done, bus.timeout_flag};
        n_cmp++;
        if (outs !== 8'h00 || last_busy != -1) begin
            n_fail++; $display("FAIL idle_after_reset: outs %b last_busy %0d required 0/-1", outs, last_busy);
        end
        $display("reset: outputs %b after release", outs);
    endtask

    task automatic test_single(input string name, input int p, input int h, input int d);
        bit ok;
        int s, n, k, m, exp_or;
        wave_en = 0; bus.cont_mode = 0;
        steps(3);
        clear_logs();
        start_req = 1; step(); s = last_c;
        steps($urandom_range(2, 8));
        wave_p = p; wave_h = h; wave_d = d; wave_stop = BIG;
        wave_t0 = last_c + 1; wave_en = 1;
        n = wave_t0;
        k = (G + p - 1) / p;
        m = n + k * p;
        wait_done(1, 3000, ok);
        steps(3);
        exp_or = 0;
        for (int c = n; c < m && c < MAXC; c++) exp_or += int'(a_rec[c] ^ b_rec[c]);

        n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_done_seen: got 0 required 1", name); end
        n_cmp++;
        if (clr_log.size() != 1 || at_or_neg(clr_log, 0) != s) begin
            n_fail++; $display("FAIL %s_cnt_clr: got n=%0d @%0d required 1 @%0d", name, clr_log.size(), at_or_neg(clr_log, 0), s);
        end
        n_cmp++;
        if (at_or_neg(en_rise_log, 0) != n + 2) begin
            n_fail++; $display("FAIL %s_gate_open: got %0d required %0d", name, at_or_neg(en_rise_log, 0), n + 2);
        end
        n_cmp++;
        if (at_or_neg(en_fall_log, 0) - at_or_neg(en_rise_log, 0) != k * p) begin
            n_fail++; $display("FAIL %s_gate_len: got %0d required %0d", name,
                               at_or_neg(en_fall_log, 0) - at_or_neg(en_rise_log, 0), k * p);
        end
        n_cmp++;
        if (or_count != exp_or) begin n_fail++; $display("FAIL %s_or_count: got %0d required %0d", name, or_count, exp_or); end
        n_cmp++;
        if (upd_log.size() != 1 || at_or_neg(upd_log, 0) != m + 4) begin
            n_fail++; $display("FAIL %s_up_data: got n=%0d @%0d required 1 @%0d", name, upd_log.size(), at_or_neg(upd_log, 0), m + 4);
        end
        n_cmp++;
        if (at_or_neg(done_log, 0) != m + 7 || last_busy != m + 7) begin
            n_fail++; $display("FAIL %s_done_busy: got done@%0d busy_last@%0d required %0d", name,
                               at_or_neg(done_log, 0), last_busy, m + 7);
        end
        n_cmp++;
        if (qup_log.size() != 0 || or_viol != 0 || bus.timeout_flag !== 1'b0) begin
            n_fail++; $display("FAIL %s_no_timeout: got q_up=%0d or_viol=%0d flag=%b required 0/0/0", name,
                               qup_log.size(), or_viol, bus.timeout_flag);
        end
        $display("meas %s: P=%0d H=%0d D=%0d gate=%0d or_en=%0d (exp %0d) up_data@%0d",
                 name, p, h, d, at_or_neg(en_fall_log, 0) - at_or_neg(en_rise_log, 0), or_count, exp_or, at_or_neg(upd_log, 0));
        wave_en = 0;
    endtask

    task automatic test_timeout_arm();
        bit ok;
        int s, exp_q;
        wave_en = 0; bus.cont_mode = 0;
        steps(3);
        clear_logs();
        start_req = 1; step(); s = last_c;
        exp_q = s + 1 + T;
        wait_done(1, T + 100, ok);
        steps(3);
        n_cmp++;
        if (qup_log.size() != 1 || at_or_neg(qup_log, 0) != exp_q) begin
            n_fail++; $display("FAIL arm_q_up: got n=%0d @%0d required 1 @%0d", qup_log.size(), at_or_neg(qup_log, 0), exp_q);
        end
        n_cmp++;
        if (at_or_neg(done_log, 0) != exp_q + 3 || !ok) begin
            n_fail++; $display("FAIL arm_done: got %0d required %0d", at_or_neg(done_log, 0), exp_q + 3);
        end
        n_cmp++;
        if (upd_log.size() != 0 || en_rise_log.size() != 0 || bus.timeout_flag !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL arm_state: got upd=%0d gates=%0d flag=%b busy=%b required 0/0/1/0",
                               upd_log.size(), en_rise_log.size(), bus.timeout_flag, bus.busy);
        end
        $display("timeout ARM: q_up@%0d done@%0d flag=%b", at_or_neg(qup_log, 0), at_or_neg(done_log, 0), bus.timeout_flag);
    endtask

    task automatic test_wait_stall();
        bit ok;
        int n, exp_q;
        wave_en = 0; bus.cont_mode = 0;
        steps(3);
        clear_logs();
        start_req = 1; step();
        step();
        n_cmp++;
        if (bus.cnt_clr !== 1'b1 || bus.timeout_flag !== 1'b0) begin
            n_fail++; $display("FAIL stall_clr_flag: got clr=%b flag=%b required 1/0", bus.cnt_clr, bus.timeout_flag);
        end
        steps(3);
        wave_p = 30; wave_h = 15; wave_d = -1;
        wave_t0 = last_c + 1; wave_en = 1;
        n = wave_t0;
        wave_stop = n + 95;
        exp_q = n + 2 + G + T;
        wait_done(1, G + T + 200, ok);
        steps(3);
        n_cmp++;
        if (qup_log.size() != 1 || at_or_neg(qup_log, 0) != exp_q || !ok) begin
            n_fail++; $display("FAIL stall_q_up: got n=%0d @%0d required 1 @%0d", qup_log.size(), at_or_neg(qup_log, 0), exp_q);
        end
        n_cmp++;
        if (at_or_neg(en_rise_log, 0) != n + 2 || at_or_neg(en_fall_log, 0) != exp_q) begin
            n_fail++; $display("FAIL stall_gate: got %0d..%0d required %0d..%0d",
                               at_or_neg(en_rise_log, 0), at_or_neg(en_fall_log, 0), n + 2, exp_q);
        end
        n_cmp++;
        if (upd_log.size() != 0 || at_or_neg(done_log, 0) != exp_q + 3 || bus.timeout_flag !== 1'b1) begin
            n_fail++; $display("FAIL stall_end: got upd=%0d done@%0d flag=%b required 0 @%0d 1",
                               upd_log.size(), at_or_neg(done_log, 0), bus.timeout_flag, exp_q + 3);
        end
        $display("timeout WAIT: gate_open@%0d q_up@%0d", at_or_neg(en_rise_log, 0), at_or_neg(qup_log, 0));
        wave_en = 0; wave_stop = BIG;
    endtask

    task automatic test_cont_mode();
        bit ok;
        int p, k, i, injected;
        p = $urandom_range(3, 60);
        k = (G + p - 1) / p;
        wave_p = p; wave_h = $urandom_range(1, p - 1); wave_d = -1; wave_stop = BIG;
        wave_t0 = last_c + 1; wave_en = 1;
        steps(5);
        clear_logs();
        bus.cont_mode = 1;
        start_req = 1; step();
        i = 0; injected = 0;
        while (upd_log.size() < 3 && i < 2000) begin
            if (bus.busy && $urandom_range(0, 3) == 0) begin start_req = 1; injected++; end
            step(); i++;
        end
        bus.cont_mode = 0;
        wait_done(3, 500, ok);
        steps(5);
        n_cmp++;
        if (clr_log.size() != 3 || upd_log.size() != 3 || done_log.size() != 3 || !ok) begin
            n_fail++; $display("FAIL cont_counts: got clr=%0d upd=%0d done=%0d required 3/3/3",
                               clr_log.size(), upd_log.size(), done_log.size());
        end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (at_or_neg(en_fall_log, j) - at_or_neg(en_rise_log, j) != k * p ||
                at_or_neg(upd_log, j) != at_or_neg(en_fall_log, j) + 2 ||
                at_or_neg(done_log, j) != at_or_neg(upd_log, j) + 3) begin
                n_fail++; $display("FAIL cont_meas%0d: got gate=%0d upd@%0d done@%0d required gate=%0d upd=fall+2 done=upd+3",
                                   j, at_or_neg(en_fall_log, j) - at_or_neg(en_rise_log, j), at_or_neg(upd_log, j),
                                   at_or_neg(done_log, j), k * p);
            end
            $display("cont meas %0d: P=%0d gate=%0d up_data@%0d done@%0d", j, p,
                     at_or_neg(en_fall_log, j) - at_or_neg(en_rise_log, j), at_or_neg(upd_log, j), at_or_neg(done_log, j));
        end
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (at_or_neg(clr_log, j + 1) != at_or_neg(upd_log, j) + 4) begin
                n_fail++; $display("FAIL cont_restart%0d: got clr@%0d required %0d", j, at_or_neg(clr_log, j + 1), at_or_neg(upd_log, j) + 4);
            end
        end
        n_cmp++;
        if (clr_viol != 0 || or_viol != 0 || both_viol != 0 || qup_log.size() != 0 || last_busy != at_or_neg(done_log, 2)) begin
            n_fail++; $display("FAIL cont_rules: got clr_viol=%0d or_viol=%0d both=%0d q_up=%0d busy_last=%0d required 0/0/0/0/%0d",
                               clr_viol, or_viol, both_viol, qup_log.size(), last_busy, at_or_neg(done_log, 2));
        end
        $display("cont: %0d ignored start pulses", injected);
        wave_en = 0;
    endtask

    task automatic test_reset_mid_gate();
        bit ok;
        int i, rst_cyc;
        logic [7:0] outs;
        bus.cont_mode = 0;
        wave_p = 20; wave_h = 10; wave_d = 5; wave_stop = BIG;
        wave_t0 = last_c + 1; wave_en = 1;
        steps(3);
        clear_logs();
        start_req = 1; step();
        i = 0;
        while (en_rise_log.size() == 0 && i < 300) begin step(); i++; end
        steps(10);
        n_cmp++;
        if (bus.cnt_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gate: got cnt_en=%b required 1", bus.cnt_en); end
        #3 rst_n = 1'b0;
        rst_cyc = cyc;
        #1;
        outs = {bus.cnt_en, bus.or_en, bus.cnt_clr, bus.up_data, bus.q_up, bus.busy, bus.done, bus.timeout_flag};
        n_cmp++;
        if (outs !== 8'h00) begin n_fail++; $display("FAIL rst_async_outs: got %b required 00000000", outs); end
        steps(3);
        #2 rst_n = 1'b1;
        steps(40);
        n_cmp++;
        if (upd_log.size() != 0 || en_rise_log.size() != 1 || last_busy > rst_cyc) begin
            n_fail++; $display("FAIL rst_stays_idle: got upd=%0d gates=%0d busy_last=%0d required 0/1/<=%0d",
                               upd_log.size(), en_rise_log.size(), last_busy, rst_cyc);
        end
        clear_logs();
        start_req = 1; step();
        wait_done(1, 400, ok);
        steps(3);
        n_cmp++;
        if (!ok || upd_log.size() != 1 || at_or_neg(en_fall_log, 0) - at_or_neg(en_rise_log, 0) != G) begin
            n_fail++; $display("FAIL rst_restart: got upd=%0d gate=%0d required 1/%0d", upd_log.size(),
                               at_or_neg(en_fall_log, 0) - at_or_neg(en_rise_log, 0), G);
        end
        $display("reset mid-gate: outs %b at reset, restart up_data@%0d", outs, at_or_neg(upd_log, 0));
        wave_en = 0;
    endtask

    initial begin
        test_reset();
        test_single("basic", 20, 10, -1);
        test_single("phase", 20, 10, 5);
        test_single("extend", 30, 15, -1);
        for (int r = 0; r < 4; r++) begin
            int p, h, d;
            p = $urandom_range(3, 60);
            h = $urandom_range(1, p - 1);
            d = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, p - 1));
            test_single("rand", p, h, d);
        end
        test_timeout_arm();
        test_wait_stall();
        test_cont_mode();
        test_reset_mid_gate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
